clk_div_ctrl: RTL
=================

# clk_div_ctrl

Runtime-programmable 50%-duty clock divider controller for any divisor (even or odd). It owns the divider counter and both edge flops, and sequences every divisor change and start/stop so that `clk_out` never glitches or produces a runt pulse. Software or a config FSM writes `{cfg_en, cfg_div}` through a valid/ready handshake. The block applies each update only at a period boundary of the divided clock.

## Interface
- `CNT_W`, 8, width of divisor and period counter
- `DEF_DIV`, 9, divisor loaded at reset; legal range 2..2^CNT_W-1
- `clk` in 1 — source clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `cfg_valid` in 1 — config request
- `cfg_ready` out 1 — block can accept a config
- `cfg_div` in CNT_W — requested divisor N
- `cfg_en` in 1 — 1 = run after update, 0 = stop after update
- `clk_out` out 1 — divided clock, 50% duty
- `running` out 1 — state is RUN
- `busy` out 1 — an accepted update is pending
- `div_cur` out CNT_W — divisor currently in effect
- `err` out 1 — one-cycle pulse, illegal divisor rejected

## Operation
- States:
  - IDLE: `clk_out` is 0 and `cnt` is held at 0.
  - RUN: the divider is counting.
  - PEND: RUN with an update latched.
- Counter: `cnt` counts 0..N-1 with N=`div_cur`, and wraps N-1→0. The posedge that loads `cnt`=0 is the period boundary.
- Waveform in RUN:
  - `clk_out` rises at every period boundary posedge.
  - Even N: `clk_out` falls at the posedge that loads `cnt`=N/2.
  - Odd N: `clk_out` falls at the clk negedge inside the cycle with `cnt`=(N-1)/2.
  - High time is N/2 clk periods exactly in both cases.
- `clk_out` is a flop output, or the AND/OR of one posedge flop and one negedge flop whose transitions never coincide. No other combinational path drives it.
- Handshake:
  - A transfer occurs at a posedge with `cfg_valid`&`cfg_ready`.
  - `cfg_ready` = !`busy`.
  - Requesters hold `cfg_valid` and data stable until the transfer.
- Legal accept (`cfg_div`≥2): `cfg_div` and `cfg_en` are latched.
  - From IDLE: applied at the next posedge.
  - From RUN: `busy`=1; applied at the next period boundary. The boundary at the accepting edge itself does not count.
- Illegal accept (`cfg_div`<2): the transfer completes. `err`=1 for the following cycle. No state, `div_cur` or waveform change.
- Apply:
  - `div_cur` ← new N and `busy` ← 0.
  - If `en`=1: state becomes RUN, `cnt`=0, and `clk_out` rises at that edge.
  - If `en`=0: state becomes IDLE and `clk_out` stays 0.
- Updates to the same N with `en`=1 are applied normally; the waveform continues unbroken.

## Timing
- Reset (async, immediate):
  - state IDLE, `cnt`=0, `clk_out`=0, both edge flops 0
  - `div_cur`=DEF_DIV, `busy`=0, `cfg_ready`=1, `running`=0, `err`=0
- Reset asserted mid-period forces `clk_out` low at once. Any pending update is discarded.
- Latency from IDLE: accept at edge T, first `clk_out` rise at edge T+1.
- Latency from RUN: accept at edge T, apply at the first period boundary after T. The worst case is N cycles.
- Accept coincident with a period boundary: the update waits one full old period.
- Stop: the last high phase always completes. `clk_out` ends low after a full low phase, with no truncated pulse.
- `running` and `busy` update at the apply edge.
- `err` asserts the cycle after acceptance and lasts exactly one cycle.

## Test plan
- Reset, then config N=9 with en=1:
  - `clk_out` rises 1 cycle after acceptance.
  - High 4.5 clk, low 4.5 clk; period 9 clk, repeating.
  - `div_cur`=9.
- N=4 running, write N=3 mid-period:
  - `busy`=1 and `cfg_ready`=0 until the boundary.
  - The N=4 period completes 2/2.
  - Next periods are high 1.5, low 1.5.
- N=2 running, write en=0:
  - The current period finishes.
  - `clk_out` stays 0 and `running`=0.
  - `cnt` holds at 0 across 20 cycles.
- Write N=1 then N=0, running at N=5:
  - `err` pulses once per write.
  - `div_cur` stays 5 and the waveform is unchanged.
  - `cfg_ready` stays 1.
- N=255 running, write N=2 at the wrap edge:
  - The change is deferred one full 255-cycle period.
  - A 1-high/1-low waveform follows.
- Assert `rst_n` while `clk_out`=1 with an update pending:
  - `clk_out` goes 0 immediately.
  - After release: IDLE, `div_cur`=9, `busy`=0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free 50% duty divider for any divisor,
// with divisor/enable changes applied only at period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             clk_out,
  output logic             running,
  output logic             busy,
  output logic [CNT_W-1:0] div_cur,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic             pend_en;
  logic             busy_q;
  logic             pos_q;
  logic             neg_q;

  logic             active;
  logic             accept;
  logic             legal;
  logic             wrap;
  logic             apply;
  logic             act_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] half;

  assign active    = (state != IDLE);
  assign running   = active;
  assign busy      = busy_q;
  assign cfg_ready = !busy_q;
  assign accept    = cfg_valid && !busy_q;
  assign legal     = (cfg_div >= CNT_W'(2));
  assign wrap      = active &&
                     (cnt == div_cur - CNT_W'(1));
  assign apply     = busy_q && (!active || wrap);
  assign half      = div_cur >> 1;

  // Odd divisors stretch the high phase by half a
  // clock through the negedge flop; edges never meet.
  assign clk_out = pos_q | neg_q;

  // Next counter, divisor and run state for this edge
  always_comb begin
    act_nxt = active;
    div_nxt = div_cur;
    cnt_nxt = '0;
    if (apply) begin
      act_nxt = pend_en;
      div_nxt = pend_div;
    end else if (active && !wrap) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Control FSM, counter and posedge half of clk_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      pend_en  <= 1'b0;
      busy_q   <= 1'b0;
      pos_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_cur <= div_nxt;
      pos_q   <= act_nxt &&
                 (cnt_nxt < (div_nxt >> 1));
      err     <= accept && !legal;
      unique case (1'b1)
        apply: begin
          busy_q <= 1'b0;
          state  <= pend_en ? RUN : IDLE;
        end
        accept && legal: begin
          busy_q   <= 1'b1;
          pend_div <= cfg_div;
          pend_en  <= cfg_en;
          if (active) state <= PEND;
        end
        default: ;
      endcase
    end
  end

  // Negedge extension covering the extra half cycle
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= active && div_cur[0] &&
               (cnt == half - CNT_W'(1));
    end
  end

endmodule
